// File: rtl/regfile.sv
// General register file feeding the ALU: latched rs1/rs2 operands, writeback source mux
// and a sticky flag for malformed stage or writeback controls.
module regfile #(
  parameter int unsigned NREG = 16,
  parameter int unsigned XLEN = 16,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      stage,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_we,
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbPc  = 2'd2;
  localparam logic [1:0] WbRsv = 2'd3;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic            err_q;

  logic            stage_valid;
  logic            rd_en, wb_stage, wr_en, wb_fault, fault;
  logic [XLEN-1:0] rd1_val, rd2_val;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign stage_valid = (stage != 4'b0000) && ((stage & (stage - 4'd1)) == 4'b0000);

  assign rd_en    = stage_valid && stage[1];
  assign wb_stage = stage_valid && stage[3] && rd_we;
  assign wb_fault = wb_stage && (wb_sel == WbRsv);
  assign wr_en    = wb_stage && (wb_sel != WbRsv) && (rd_addr != '0);
  assign fault    = !stage_valid || wb_fault;

  // r0 is never written, but force zero on the read side too so it holds by construction.
  assign rd1_val = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
  assign rd2_val = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];

  always_comb begin
    wb_data = '0;
    unique case (wb_sel)
      WbAlu:   wb_data = alu_out;
      WbMem:   wb_data = mem_rdata;
      WbPc:    wb_data = pc + XLEN'(1);
      WbRsv:   wb_data = '0;
      default: wb_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      rs1_q <= '0;
      rs2_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (rd_en) begin
        rs1_q <= rd1_val;
        rs2_q <= rd2_val;
      end
      if (wr_en) begin
        regs_q[rd_addr] <= wb_data;
      end
      if (fault) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rs1 = rs1_q;
  assign rs2 = rs2_q;
  assign err = err_q;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, read/write, r0, writeback sources,
// faults and reset during writeback.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic [3:0]  stage;
  logic [3:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_we;
  logic [1:0]  wb_sel;
  logic [15:0] alu_out, mem_rdata, pc;
  logic [15:0] rs1, rs2, wb_data;
  logic        err;

  int unsigned n_chk;
  int unsigned n_pass;

  regfile #(
    .NREG(16),
    .XLEN(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stage    (stage),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .rd_we    (rd_we),
    .wb_sel   (wb_sel),
    .alu_out  (alu_out),
    .mem_rdata(mem_rdata),
    .pc       (pc),
    .rs1      (rs1),
    .rs2      (rs2),
    .wb_data  (wb_data),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stage = 4'b0001;
    rd_we = 1'b0;
    step();
  endtask

  task automatic write(input logic [3:0] rd, input logic [1:0] sel, input logic [15:0] alu,
                       input logic [15:0] mem, input logic [15:0] pcv);
    stage     = 4'b1000;
    rd_we     = 1'b1;
    rd_addr   = rd;
    wb_sel    = sel;
    alu_out   = alu;
    mem_rdata = mem;
    pc        = pcv;
    step();
    idle();
  endtask

  task automatic read(input logic [3:0] a1, input logic [3:0] a2);
    stage    = 4'b0010;
    rd_we    = 1'b0;
    rs1_addr = a1;
    rs2_addr = a2;
    step();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    stage = 4'b0001;
    rs1_addr = '0;
    rs2_addr = '0;
    rd_addr = '0;
    rd_we = 1'b0;
    wb_sel = 2'd0;
    alu_out = '0;
    mem_rdata = '0;
    pc = '0;
    #2;
    step();
    rst = 1'b0;
    check("reset_rs1", rs1, 16'h0000);
    check("reset_rs2", rs2, 16'h0000);
    check("reset_err", {15'b0, err}, 16'h0000);

    read(4'd5, 4'd9);
    check("read_zero_rs1", rs1, 16'h0000);
    check("read_zero_rs2", rs2, 16'h0000);

    // Combinational mux checks
    wb_sel = 2'd0; alu_out = 16'hA5C3; #1;
    check("mux_alu", wb_data, 16'hA5C3);
    wb_sel = 2'd1; mem_rdata = 16'h1234; #1;
    check("mux_mem", wb_data, 16'h1234);
    wb_sel = 2'd2; pc = 16'h1234; #1;
    check("mux_pc_inc", wb_data, 16'h1235);
    pc = 16'hFFFF; #1;
    check("mux_pc_wrap", wb_data, 16'h0000);
    wb_sel = 2'd3; #1;
    check("mux_rsv", wb_data, 16'h0000);

    write(4'd3, 2'd0, 16'hA5C3, 16'h0000, 16'h0000);
    read(4'd3, 4'd0);
    check("wr_rd_r3", rs1, 16'hA5C3);
    check("wr_rd_r0", rs2, 16'h0000);

    write(4'd0, 2'd0, 16'hFFFF, 16'h0000, 16'h0000);
    read(4'd0, 4'd3);
    check("r0_immune", rs1, 16'h0000);
    check("r0_r3_intact", rs2, 16'hA5C3);
    check("r0_no_err", {15'b0, err}, 16'h0000);

    write(4'd4, 2'd1, 16'h0000, 16'h1234, 16'h0000);
    write(4'd5, 2'd0, 16'h7777, 16'h0000, 16'h0000);
    write(4'd5, 2'd2, 16'h0000, 16'h0000, 16'hFFFF);
    read(4'd4, 4'd5);
    check("wb_mem_r4", rs1, 16'h1234);
    check("wb_pc_wrap_r5", rs2, 16'h0000);

    // Operands hold through execute even with new addresses
    stage = 4'b0100; rs1_addr = 4'd3; rs2_addr = 4'd3; step();
    check("hold_ex_rs1", rs1, 16'h1234);
    check("hold_ex_rs2", rs2, 16'h0000);

    // Reserved writeback source: no write, err set
    write(4'd4, 2'd3, 16'h9999, 16'h9999, 16'h9999);
    check("rsv_err", {15'b0, err}, 16'h0001);
    read(4'd4, 4'd3);
    check("rsv_no_write", rs1, 16'h1234);

    rst = 1'b1; step(); rst = 1'b0;
    check("rst_clr_err", {15'b0, err}, 16'h0000);
    check("rst_clr_rs1", rs1, 16'h0000);
    read(4'd4, 4'd3);
    check("rst_clr_r4", rs1, 16'h0000);
    check("rst_clr_r3", rs2, 16'h0000);

    // Invalid stage: no latch, err sticky
    write(4'd6, 2'd0, 16'h4321, 16'h0000, 16'h0000);
    read(4'd6, 4'd6);
    check("pre_inv_rs1", rs1, 16'h4321);
    stage = 4'b0110; rs1_addr = 4'd0; rs2_addr = 4'd0; step();
    check("inv_hold_rs1", rs1, 16'h4321);
    check("inv_hold_rs2", rs2, 16'h4321);
    check("inv_err", {15'b0, err}, 16'h0001);
    for (int i = 0; i < 10; i++) idle();
    check("err_sticky", {15'b0, err}, 16'h0001);
    stage = 4'b1010; rd_we = 1'b1; rd_addr = 4'd6; wb_sel = 2'd0; alu_out = 16'h1111; step();
    idle();
    read(4'd6, 4'd0);
    check("inv_no_write", rs1, 16'h4321);

    // Reset concurrent with a valid writeback aborts it
    stage = 4'b1000; rd_we = 1'b1; rd_addr = 4'd7; wb_sel = 2'd0; alu_out = 16'hBEEF;
    rst = 1'b1; step(); rst = 1'b0;
    idle();
    read(4'd7, 4'd6);
    check("rst_wb_r7", rs1, 16'h0000);
    check("rst_wb_r6", rs2, 16'h0000);
    check("rst_wb_err", {15'b0, err}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
